// File: rtl/tx_lane_pkg.sv
// Shared types and helpers for the TX lane distributor: lane geometry, the
// decoded per-beat lane bundle, and tkeep inspection functions.
package tx_lane_pkg;

  localparam int PKG_DWIDTH    = 240;
  localparam int PKG_N_CHANNEL = 3;
  localparam int LANE_W        = PKG_DWIDTH / PKG_N_CHANNEL;
  localparam int LANE_BYTES    = LANE_W / 8;
  localparam int BCW           = $clog2(LANE_BYTES + 1);
  localparam int KEEP_W        = PKG_DWIDTH / 8;

  typedef struct packed {
    logic [PKG_N_CHANNEL-1:0][LANE_W-1:0] data;
    logic [PKG_N_CHANNEL-1:0]             valid;
    logic [PKG_N_CHANNEL-1:0]             last;
    logic [PKG_N_CHANNEL-1:0][BCW-1:0]    bytes;
  } lane_beat_t;

  function automatic logic [BCW-1:0] keep_popcount(input logic [LANE_BYTES-1:0] k);
    logic [BCW-1:0] n;
    n = '0;
    for (int b = 0; b < LANE_BYTES; b++) n = n + BCW'(k[b]);
    return n;
  endfunction

  // Valid keep is a run of ones from the MSB: no set byte below a cleared one.
  function automatic logic keep_contiguous(input logic [KEEP_W-1:0] k);
    logic seen0;
    logic ok;
    seen0 = 1'b0;
    ok    = 1'b1;
    for (int b = KEEP_W - 1; b >= 0; b--) begin
      if (!k[b]) seen0 = 1'b1;
      else if (seen0) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// One-entry skid buffer in front of an output register. Upstream ready is a
// register, so it never depends combinationally on downstream ready.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready
);

  logic [W-1:0] r_skid_p0, r_out_p1;
  logic         r_skid_vld_p0, r_out_vld_p1, r_rdy;
  logic [W-1:0] w_skid_nxt, w_out_nxt;
  logic         w_skid_vld_nxt, w_out_vld_nxt, w_acc, w_load;

  always_comb begin
    w_skid_nxt     = r_skid_p0;
    w_skid_vld_nxt = r_skid_vld_p0;
    w_out_nxt      = r_out_p1;
    w_out_vld_nxt  = r_out_vld_p1;
    w_acc          = i_s_valid && r_rdy;
    w_load         = !r_out_vld_p1 || i_m_ready;
    if (w_load) begin
      if (r_skid_vld_p0) begin
        w_out_nxt      = r_skid_p0;
        w_out_vld_nxt  = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end else if (w_acc) begin
        w_out_nxt     = i_s_data;
        w_out_vld_nxt = 1'b1;
      end else begin
        w_out_nxt     = '0;
        w_out_vld_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_skid_nxt     = i_s_data;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Stage p0 (skid entry) -> p1 (output register)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_p0     <= '0;
      r_skid_vld_p0 <= 1'b0;
      r_out_p1      <= '0;
      r_out_vld_p1  <= 1'b0;
      r_rdy         <= 1'b0;
    end else begin
      r_skid_p0     <= w_skid_nxt;
      r_skid_vld_p0 <= w_skid_vld_nxt;
      r_out_p1      <= w_out_nxt;
      r_out_vld_p1  <= w_out_vld_nxt;
      r_rdy         <= !w_skid_vld_nxt;
    end
  end

  assign o_s_ready = r_rdy;
  assign o_m_data  = r_out_p1;
  assign o_m_valid = r_out_vld_p1;

endmodule

// File: rtl/tx_lane_dist.sv
// Splits each 240-bit MSB-aligned AXIS beat across N_CHANNEL lanes with
// per-lane valid/last/byte count. Optional counters under TX_LANE_STATS_EN.
module tx_lane_dist
  import tx_lane_pkg::*;
#(
  parameter int DWIDTH    = PKG_DWIDTH,
  parameter int N_CHANNEL = PKG_N_CHANNEL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH-1:0]         s_axis_tdata,
  input  logic [DWIDTH/8-1:0]       s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [N_CHANNEL*LANE_W-1:0] m_lane_tdata,
  output logic [N_CHANNEL-1:0]      m_lane_tvalid,
  output logic [N_CHANNEL-1:0]      m_lane_tlast,
  output logic [N_CHANNEL*BCW-1:0]  m_lane_bytes,
  input  logic                      m_lane_tready,
  output logic                      err_keep
`ifdef TX_LANE_STATS_EN
  ,
  output logic [31:0]               stat_pkts,
  output logic [47:0]               stat_bytes
`endif
);

  lane_beat_t           w_dec_p0, w_out_p1;
  logic [N_CHANNEL:0]   w_top_below;
  logic                 w_in_vld, w_out_vld, w_acc, w_keep_bad;
  logic                 r_err_keep;

  // Decode keep into lane fields; last goes to the lowest lane still carrying data.
  always_comb begin
    w_dec_p0      = '0;
    w_dec_p0.data = s_axis_tdata;
    for (int i = 0; i < N_CHANNEL; i++) begin
      w_dec_p0.valid[i] = s_axis_tkeep[(i+1)*LANE_BYTES-1];
      w_dec_p0.bytes[i] = keep_popcount(s_axis_tkeep[i*LANE_BYTES +: LANE_BYTES]);
    end
    w_top_below = {w_dec_p0.valid, 1'b0};
    for (int i = 0; i < N_CHANNEL; i++)
      w_dec_p0.last[i] = s_axis_tlast && w_dec_p0.valid[i] && !w_top_below[i];
  end

  // Beats with no lane valid produce nothing downstream and are dropped here.
  assign w_in_vld   = s_axis_tvalid && (|w_dec_p0.valid);
  assign w_acc      = s_axis_tvalid && s_axis_tready;
  assign w_keep_bad = (s_axis_tkeep == '0) ? s_axis_tlast : !keep_contiguous(s_axis_tkeep);

  axis_skid_buf #(.W($bits(lane_beat_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_s_data  (w_dec_p0),
    .i_s_valid (w_in_vld),
    .o_s_ready (s_axis_tready),
    .o_m_data  (w_out_p1),
    .o_m_valid (w_out_vld),
    .i_m_ready (m_lane_tready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_err_keep <= 1'b0;
    else if (w_acc && w_keep_bad) r_err_keep <= 1'b1;
  end

  assign err_keep      = r_err_keep;
  assign m_lane_tdata  = w_out_p1.data;
  assign m_lane_tvalid = w_out_p1.valid & {N_CHANNEL{w_out_vld}};
  assign m_lane_tlast  = w_out_p1.last;
  assign m_lane_bytes  = w_out_p1.bytes;

`ifdef TX_LANE_STATS_EN
  logic        w_xfer;
  logic [47:0] w_sum;
  logic [31:0] r_stat_pkts;
  logic [47:0] r_stat_bytes;

  assign w_xfer = (|m_lane_tvalid) && m_lane_tready;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CHANNEL; i++) w_sum = w_sum + 48'(w_out_p1.bytes[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_pkts  <= '0;
      r_stat_bytes <= '0;
    end else if (w_xfer) begin
      if (|m_lane_tlast) r_stat_pkts <= r_stat_pkts + 32'd1;
      r_stat_bytes <= r_stat_bytes + w_sum;
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_bytes = r_stat_bytes;
`endif

endmodule

// File: tb/tb_tx_lane_dist.sv
// Scoreboard bench for tx_lane_dist: accepted beats are decoded by a reference
// model into a queue and compared against each lane output transfer.
module tb_tx_lane_dist;

  logic         clk = 1'b0;
  logic         rst;
  logic [239:0] s_axis_tdata;
  logic [29:0]  s_axis_tkeep;
  logic         s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [239:0] m_lane_tdata;
  logic [2:0]   m_lane_tvalid, m_lane_tlast;
  logic [11:0]  m_lane_bytes;
  logic         m_lane_tready, err_keep;
`ifdef TX_LANE_STATS_EN
  logic [31:0]  stat_pkts;
  logic [47:0]  stat_bytes;
`endif

  always #5 clk = ~clk;

  tx_lane_dist dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_lane_tdata  (m_lane_tdata),
    .m_lane_tvalid (m_lane_tvalid),
    .m_lane_tlast  (m_lane_tlast),
    .m_lane_bytes  (m_lane_bytes),
    .m_lane_tready (m_lane_tready),
    .err_keep      (err_keep)
`ifdef TX_LANE_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_bytes    (stat_bytes)
`endif
  );

  typedef struct packed {
    logic [239:0] d;
    logic [2:0]   v;
    logic [2:0]   l;
    logic [11:0]  b;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0, n_out = 0, cyc = 0;
  int   out_cyc[$];
  bit   saw_rdy_low;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [239:0] d, input logic [29:0] k, input logic l);
    exp_t e;
    logic prev;
    int   cnt;
    e    = '0;
    e.d  = d;
    prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 10; j++) cnt += int'(k[i*10+j]);
      e.b[i*4 +: 4] = 4'(cnt);
      e.v[i] = k[i*10+9];
      e.l[i] = l && e.v[i] && !prev;
      prev   = e.v[i];
    end
    return e;
  endfunction

  function automatic logic [239:0] rnd240();
    logic [255:0] x;
    x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return x[239:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (!s_axis_tready) saw_rdy_low = 1'b1;
      if ((|m_lane_tvalid) && m_lane_tready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sb_q.size() == 0) check_eq("out_unexpected", m_lane_tvalid, 0);
        else begin
          mon_e = sb_q.pop_front();
          check_eq("out_data",  m_lane_tdata,  mon_e.d);
          check_eq("out_valid", m_lane_tvalid, mon_e.v);
          check_eq("out_last",  m_lane_tlast,  mon_e.l);
          check_eq("out_bytes", m_lane_bytes,  mon_e.b);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        mon_e = model(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
        if (|mon_e.v) sb_q.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [239:0] d, input logic [29:0] k, input logic l);
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("send_timeout", s_axis_tready, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("out_count", n_out, target);
  endtask

  int base;

  initial begin
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; m_lane_tready = 1'b1; saw_rdy_low = 1'b0;
    #12;
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_tvalid", m_lane_tvalid, 0);
    check_eq("rst_tdata",  m_lane_tdata, 0);
    check_eq("rst_err",    err_keep, 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_tready", s_axis_tready, 1);

    // Full beat, then an 18-byte EOP beat
    send(rnd240(), 30'h3FFFFFFF, 1'b0);
    check_eq("full_valid", m_lane_tvalid, 3'b111);
    check_eq("full_bytes", m_lane_bytes, {4'd10, 4'd10, 4'd10});
    check_eq("full_last",  m_lane_tlast, 3'b000);
    wait_outs(1);
    send(rnd240(), 30'h3FFFF000, 1'b1);
    check_eq("eop_valid", m_lane_tvalid, 3'b110);
    check_eq("eop_bytes", m_lane_bytes, {4'd10, 4'd8, 4'd0});
    check_eq("eop_last",  m_lane_tlast, 3'b010);
    wait_outs(2);

    // Back-to-back 5-beat packet
    base = n_out;
    out_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      send(rnd240(), (i == 4) ? 30'h3FFFFFC0 : 30'h3FFFFFFF, i == 4);
      check_eq("b2b_tready", s_axis_tready, 1);
    end
    wait_outs(base + 5);
    check_eq("b2b_consecutive", out_cyc[4] - out_cyc[0], 4);

    // Backpressure: 3 cycles of ready low during a 6-beat stream
    base = n_out;
    saw_rdy_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(rnd240(), (i == 5) ? 30'h3FF00000 : 30'h3FFFFFFF, i == 5);
      end
      begin
        @(posedge clk); #1 m_lane_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_lane_tready = 1'b1;
      end
    join
    wait_outs(base + 6);
    check_eq("bp_tready_dropped", saw_rdy_low, 1);
    check_eq("bp_sb_empty", sb_q.size(), 0);

    // Empty keep with last: discarded, flags error
    base = n_out;
    check_eq("err_before", err_keep, 0);
    send(rnd240(), 30'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("zero_keep_err", err_keep, 1);
    check_eq("zero_keep_no_out", n_out, base);

    // Non-contiguous keep after reset
    rst = 1'b1;
    #3 rst = 1'b0;
    check_eq("err_cleared", err_keep, 0);
    @(posedge clk); #1;
    send(rnd240(), 30'h3F0F0000, 1'b0);
    check_eq("nc_err",   err_keep, 1);
    check_eq("nc_valid", m_lane_tvalid, 3'b110);
    check_eq("nc_bytes", m_lane_bytes, {4'd6, 4'd4, 4'd0});
    check_eq("nc_last",  m_lane_tlast, 3'b000);
    wait_outs(n_out + 1);

    // Async reset with skid full
    m_lane_tready = 1'b0;
    send(rnd240(), 30'h3FFFFFFF, 1'b0);
    send(rnd240(), 30'h3FFFFFFF, 1'b0);
    @(posedge clk); #1;
    check_eq("skid_full_tready", s_axis_tready, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_tvalid", m_lane_tvalid, 0);
    check_eq("arst_tdata",  m_lane_tdata, 0);
    check_eq("arst_bytes",  m_lane_bytes, 0);
    check_eq("arst_tready", s_axis_tready, 0);
`ifdef TX_LANE_STATS_EN
    check_eq("arst_stat_pkts",  stat_pkts, 0);
    check_eq("arst_stat_bytes", stat_bytes, 0);
`endif
    sb_q.delete();
    #2 rst = 1'b0;
    m_lane_tready = 1'b1;
    @(posedge clk); #1;
    base = n_out;
    send(rnd240(), 30'h3FFFFFFF, 1'b0);
    send(rnd240(), 30'h3FFFFC00, 1'b1);
    wait_outs(base + 2);
`ifdef TX_LANE_STATS_EN
    check_eq("stat_pkts",  stat_pkts, 1);
    check_eq("stat_bytes", stat_bytes, 50);
`endif
    check_eq("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
